key_multi: RTL and testbench
============================

KEY_MULTI -- requirements
Module: key_multi

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100000000, meaning clk_i frequency in Hz.
REQ-002 The block SHALL have parameter KEY_NUM, default 4, meaning number of independent key channels (1..32).
REQ-003 The block SHALL have parameter DEBOUNCE_MS, default 10, meaning sample-tick period in ms.
REQ-004 The block SHALL have parameter LONG_MS, default 1000, meaning hold time before the long-press event, an integer multiple of DEBOUNCE_MS.
REQ-005 The block SHALL have parameter REPEAT_MS, default 200, meaning auto-repeat period after long press, an integer multiple of DEBOUNCE_MS, with REPEAT_MS <= LONG_MS.
REQ-006 The block SHALL have port clk_i, input, width 1, meaning the single system clock; all logic is clocked on its rising edge.
REQ-007 The block SHALL have port rst_n_i, input, width 1, meaning asynchronous, active-low reset.
REQ-008 The block SHALL have port key_i, input, width KEY_NUM, meaning raw asynchronous key inputs, active-low (0 = pressed).
REQ-009 The block SHALL have port key_state_o, output, width KEY_NUM, meaning debounced level per channel (1 = pressed).
REQ-010 The block SHALL have port key_press_o, output, width KEY_NUM, meaning one-cycle pulse on confirmed press.
REQ-011 The block SHALL have port key_release_o, output, width KEY_NUM, meaning one-cycle pulse on confirmed release.
REQ-012 The block SHALL have port key_long_o, output, width KEY_NUM, meaning one-cycle pulse when hold reaches LONG_MS.
REQ-013 The block SHALL have port key_repeat_o, output, width KEY_NUM, meaning one-cycle pulse every REPEAT_MS after long press while held.

Function
REQ-014 The block SHALL have one shared tick counter counting 0..TICK_MAX = CLK_FREQ/1000*DEBOUNCE_MS-1, then wrapping to 0; tick is high for exactly the one cycle in which the count equals TICK_MAX.
REQ-015 Each key_i bit SHALL pass through a 2-flop synchroniser before use; the FSM samples only the synchronised value.
REQ-016 Each channel SHALL run its own 4-state FSM, advancing only on tick cycles: IDLE (low->PRESS_CHK); PRESS_CHK (low->HELD, high->IDLE); HELD (high->REL_CHK); REL_CHK (high->IDLE, low->HELD).
REQ-017 key_state_o[n] SHALL be 1 while channel n is in HELD or REL_CHK, and 0 otherwise.
REQ-018 key_press_o[n] SHALL be registered and high for the one cycle after the edge on which PRESS_CHK->HELD occurs; key_release_o[n] SHALL behave likewise for REL_CHK->IDLE.
REQ-019 Each channel SHALL have a hold counter of width $clog2(LONG_MS/DEBOUNCE_MS+1)+1 that clears to 0 on entry to HELD from PRESS_CHK and increments on each tick while in HELD or REL_CHK.
REQ-020 key_long_o[n] SHALL pulse once when the hold counter reaches LONG_TICKS = LONG_MS/DEBOUNCE_MS.
REQ-021 After the long pulse, key_repeat_o[n] SHALL pulse once every REPEAT_MS/DEBOUNCE_MS ticks until release, using a separate repeat counter restarted at each repeat pulse; the hold counter saturates at LONG_TICKS.
REQ-022 A REL_CHK->HELD bounce SHALL preserve the hold and repeat counters, and no release pulse is emitted.
REQ-023 On REL_CHK->IDLE both counters SHALL clear; repeat and long pulses are suppressed in that same tick.
REQ-024 A release before LONG_TICKS SHALL produce press and release pulses only.
REQ-025 Channels SHALL be fully independent; simultaneous events on several channels SHALL produce simultaneous pulses on their respective bits.
REQ-026 At most one of press, long or repeat SHALL pulse per channel per tick; long takes priority over repeat.

Reset
REQ-027 While rst_n_i = 0, the tick counter, synchronisers (to 1 = released), FSMs (to IDLE), counters and all outputs SHALL be 0 immediately, without waiting for a clock edge.
REQ-028 A reset asserted mid-hold SHALL discard the press, and no release pulse SHALL follow deassertion.
REQ-029 After reset deassertion, the first tick SHALL occur TICK_MAX+1 cycles later.

Verification (CLK_FREQ=1000, KEY_NUM=2, DEBOUNCE_MS=10, LONG_MS=100, REPEAT_MS=50, so 10 cycles per tick)
REQ-030 Clean press: key_i[0] held low for 3 ticks -> exactly one press pulse on the second tick after synchronisation, and key_state_o[0] = 1.
REQ-031 Glitch: key_i[0] low for 5 cycles spanning one tick -> no pulses, and key_state_o stays 0.
REQ-032 Long hold: key_i[0] low for 25 ticks -> press, then long at hold 10, then repeats at holds 15 and 20, then a release pulse after key_i returns high for 2 ticks.
REQ-033 Release bounce: while held, key_i high for 1 tick then low -> no release pulse, and hold count continues unbroken.
REQ-034 Two channels pressed in the same cycle -> key_press_o = 2'b11 for one cycle; release ch1 only -> key_release_o = 2'b10.
REQ-035 Reset mid-hold: rst_n_i low at hold 7 -> all outputs 0 asynchronously; after release and reset deassertion, no pulses occur.

Source files
------------

// File: rtl/key_multi.sv
// key_multi: multi-channel key debouncer with press/release/long-press/auto-repeat pulses
//   clk_i         system clock, rising edge
//   rst_n_i       asynchronous active-low reset
//   key_i         raw keys, active-low (0 = pressed)
//   key_state_o   debounced level per channel (1 = pressed)
//   key_press_o   one-cycle pulse on confirmed press
//   key_release_o one-cycle pulse on confirmed release
//   key_long_o    one-cycle pulse when the hold reaches LONG_MS
//   key_repeat_o  one-cycle pulse every REPEAT_MS after the long pulse while held
module key_multi #(
  parameter int CLK_FREQ    = 100000000,
  parameter int KEY_NUM     = 4,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [KEY_NUM-1:0] key_i,
  output logic [KEY_NUM-1:0] key_state_o,
  output logic [KEY_NUM-1:0] key_press_o,
  output logic [KEY_NUM-1:0] key_release_o,
  output logic [KEY_NUM-1:0] key_long_o,
  output logic [KEY_NUM-1:0] key_repeat_o
);
  localparam int TICK_MAX     = CLK_FREQ / 1000 * DEBOUNCE_MS - 1;
  localparam int TW           = TICK_MAX > 0 ? $clog2(TICK_MAX + 1) : 1;
  localparam int LONG_TICKS   = LONG_MS / DEBOUNCE_MS;
  localparam int REPEAT_TICKS = REPEAT_MS / DEBOUNCE_MS;
  localparam int HW           = $clog2(LONG_TICKS + 1) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_MAX);
  localparam logic [HW-1:0] LONG_C    = HW'(LONG_TICKS);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

  logic [TW-1:0]      tick_cnt;
  logic               tick;
  logic [KEY_NUM-1:0] sync_a, sync_b;

  assign tick = tick_cnt == TICK_LAST;

  // synchronisers reset to "released" so no phantom press follows reset
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      tick_cnt <= '0;
      sync_a   <= '1;
      sync_b   <= '1;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      sync_a   <= key_i;
      sync_b   <= sync_a;
    end

  for (genvar k = 0; k < KEY_NUM; k++) begin : g_ch
    state_t        st, st_n;
    logic [HW-1:0] hold, hold_n, rep, rep_n;
    logic          low, press_n, rel_n, long_n, rpt_n;
    logic          press_q, rel_q, long_q, rpt_q;

    assign low = ~sync_b[k];

    always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
        st      <= IDLE;
        hold    <= '0;
        rep     <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        rpt_q   <= 1'b0;
      end else begin
        st      <= st_n;
        hold    <= hold_n;
        rep     <= rep_n;
        press_q <= press_n;
        rel_q   <= rel_n;
        long_q  <= long_n;
        rpt_q   <= rpt_n;
      end

    always_comb begin
      st_n    = st;
      hold_n  = hold;
      rep_n   = rep;
      press_n = 1'b0;
      rel_n   = 1'b0;
      long_n  = 1'b0;
      rpt_n   = 1'b0;
      if (tick) begin
        case (st)
          IDLE: st_n = low ? PRESS_CHK : IDLE;
          PRESS_CHK: begin
            st_n    = low ? HELD : IDLE;
            press_n = low;
            hold_n  = '0;
            rep_n   = '0;
          end
          default: begin
            if (st == REL_CHK && !low) begin
              st_n   = IDLE;
              rel_n  = 1'b1;
              hold_n = '0;
              rep_n  = '0;
            end else begin
              st_n = low ? HELD : REL_CHK;
              // once the hold counter has saturated, the repeat counter takes over
              if (hold == LONG_C) begin
                rpt_n = rep == REP_LAST;
                rep_n = rpt_n ? '0 : rep + HW'(1);
              end else begin
                long_n = hold == LONG_LAST;
                hold_n = hold + HW'(1);
              end
            end
          end
        endcase
      end
    end

    assign key_state_o[k]   = st == HELD || st == REL_CHK;
    assign key_press_o[k]   = press_q;
    assign key_release_o[k] = rel_q;
    assign key_long_o[k]    = long_q;
    assign key_repeat_o[k]  = rpt_q;
  end
endmodule

// File: tb/tb_key_multi.sv
// tb_key_multi: table-driven, hand-sequenced and randomized checks of key_multi against a behavioural model
module tb_key_multi;
  localparam int LT = 10;
  localparam int RT = 5;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] key = 2'b11;
  logic [1:0] key_state_o, key_press_o, key_release_o, key_long_o, key_repeat_o;

  key_multi #(
    .CLK_FREQ(1000), .KEY_NUM(2), .DEBOUNCE_MS(10), .LONG_MS(100), .REPEAT_MS(50)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n), .key_i(key),
    .key_state_o(key_state_o), .key_press_o(key_press_o), .key_release_o(key_release_o),
    .key_long_o(key_long_o), .key_repeat_o(key_repeat_o)
  );

  always #5 clk_i = ~clk_i;

  // behavioural model: a level flips after two consecutive disagreeing tick samples;
  // ht counts ticks since the press
  logic [1:0] m_s1, m_s2, e_state, e_press, e_rel, e_long, e_rep;
  int         m_cnt;
  int         streak[2];
  int         ht[2];

  task automatic model_reset();
    m_s1 = 2'b11; m_s2 = 2'b11; m_cnt = 0;
    e_state = '0; e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
    for (int i = 0; i < 2; i++) begin streak[i] = 0; ht[i] = 0; end
  endtask

  task automatic model_step();
    bit tk, lo, flip;
    tk = m_cnt == 9;
    e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
    if (tk)
      for (int i = 0; i < 2; i++) begin
        lo = !m_s2[i];
        flip = 0;
        if (lo != e_state[i]) begin streak[i]++; flip = streak[i] == 2; end
        else streak[i] = 0;
        if (flip) begin
          e_state[i] = lo; streak[i] = 0; ht[i] = 0;
          e_press[i] = lo; e_rel[i] = !lo;
        end else if (e_state[i]) begin
          ht[i]++;
          e_long[i] = ht[i] == LT;
          e_rep[i]  = ht[i] > LT && (ht[i] - LT) % RT == 0;
        end
      end
    m_s2 = m_s1; m_s1 = key;
    m_cnt = tk ? 0 : m_cnt + 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_i or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  int n_chk = 0, n_fail = 0;
  int cp[2], cr[2], cl[2], ct[2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 2; i++) begin cp[i] = 0; cr[i] = 0; cl[i] = 0; ct[i] = 0; end
  endtask

  // one clock: sample at the falling edge, compare with the model, accumulate pulse counts
  task automatic cyc();
    @(negedge clk_i);
    chk("model", {22'd0, key_state_o, key_press_o, key_release_o, key_long_o, key_repeat_o},
        {22'd0, e_state, e_press, e_rel, e_long, e_rep});
    for (int i = 0; i < 2; i++) begin
      cp[i] += int'(key_press_o[i]);
      cr[i] += int'(key_release_o[i]);
      cl[i] += int'(key_long_o[i]);
      ct[i] += int'(key_repeat_o[i]);
    end
  endtask

  function automatic logic [7:0] pk(input int a[2]);
    return {4'(a[1]), 4'(a[0])};
  endfunction

  typedef struct {
    logic [1:0] key;
    int         n;
    logic [7:0] np, nr, nl, nt;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int first;
    tbl[0]  = '{2'b11, 20,  8'h00, 8'h00, 8'h00, 8'h00, 2'b00};
    tbl[1]  = '{2'b10, 30,  8'h01, 8'h00, 8'h00, 8'h00, 2'b01};
    tbl[2]  = '{2'b11, 30,  8'h00, 8'h01, 8'h00, 8'h00, 2'b00};
    tbl[3]  = '{2'b11, 5,   8'h00, 8'h00, 8'h00, 8'h00, 2'b00};
    tbl[4]  = '{2'b10, 5,   8'h00, 8'h00, 8'h00, 8'h00, 2'b00};
    tbl[5]  = '{2'b11, 30,  8'h00, 8'h00, 8'h00, 8'h00, 2'b00};
    tbl[6]  = '{2'b10, 250, 8'h01, 8'h00, 8'h01, 8'h02, 2'b01};
    tbl[7]  = '{2'b11, 10,  8'h00, 8'h00, 8'h00, 8'h00, 2'b01};
    tbl[8]  = '{2'b10, 20,  8'h00, 8'h00, 8'h00, 8'h01, 2'b01};
    tbl[9]  = '{2'b11, 30,  8'h00, 8'h01, 8'h00, 8'h00, 2'b00};
    tbl[10] = '{2'b00, 30,  8'h11, 8'h00, 8'h00, 8'h00, 2'b11};
    tbl[11] = '{2'b10, 30,  8'h00, 8'h10, 8'h00, 8'h00, 2'b01};
    tbl[12] = '{2'b11, 30,  8'h00, 8'h01, 8'h00, 8'h00, 2'b00};

    repeat (3) cyc();
    chk("reset_outputs", {22'd0, key_state_o, key_press_o, key_release_o, key_long_o, key_repeat_o}, 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 13; v++) begin
      key = tbl[v].key;
      clr_counts();
      repeat (tbl[v].n) cyc();
      chk($sformatf("row%0d_press", v),   {24'd0, pk(cp)}, {24'd0, tbl[v].np});
      chk($sformatf("row%0d_release", v), {24'd0, pk(cr)}, {24'd0, tbl[v].nr});
      chk($sformatf("row%0d_long", v),    {24'd0, pk(cl)}, {24'd0, tbl[v].nl});
      chk($sformatf("row%0d_repeat", v),  {24'd0, pk(ct)}, {24'd0, tbl[v].nt});
      chk($sformatf("row%0d_state", v),   {30'd0, key_state_o}, {30'd0, tbl[v].st});
    end

    // reset at hold 7: outputs drop without a clock edge, and nothing follows deassertion
    key = 2'b10;
    repeat (90) cyc();
    chk("pre_reset_state", {30'd0, key_state_o}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("async_reset", {22'd0, key_state_o, key_press_o, key_release_o, key_long_o, key_repeat_o}, 32'd0);
    key = 2'b11;
    repeat (3) cyc();
    rst_n = 1'b1;
    clr_counts();
    repeat (50) cyc();
    chk("post_reset_pulses", {pk(cp), pk(cr), pk(cl), pk(ct)}, 32'd0);
    chk("post_reset_state", {30'd0, key_state_o}, 32'd0);

    // first tick lands TICK_MAX+1 cycles after deassertion, so the press shows on cycle 20
    rst_n = 1'b0;
    key = 2'b01;
    repeat (2) cyc();
    rst_n = 1'b1;
    first = 0;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      if (key_press_o[1] && first == 0) first = c;
    end
    chk("first_tick_press_cycle", first, 20);

    for (int r = 0; r < 40; r++) begin
      key = 2'($urandom);
      repeat (($urandom_range(0, 3) == 0) ? $urandom_range(100, 300) : $urandom_range(1, 30)) cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
